// File: rtl/tdc_therm_decoder.sv
// Decodes UP/DWN thermometer codes from the TDC into a signed phase error per pulse event.
// Publishes 2 clk after the first all-zero input sample; no backpressure (err_valid is a strobe).
module tdc_therm_decoder #(
  parameter int TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] up_error,
  input  logic [31:0] dwn_error,
  output logic [6:0]  phase_err,
  output logic        err_valid,
  output logic        err_sat,
  output logic        err_bubble,
  output logic        err_timeout,
  output logic [15:0] meas_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam logic [6:0] TIMEOUT_W = 7'(TIMEOUT);

  state_t      state;
  logic [31:0] up_q;
  logic [31:0] dwn_q;
  logic [5:0]  max_up;
  logic [5:0]  max_dn;
  logic [5:0]  timer;
  logic        sat_acc;
  logic        bub_acc;

  logic [5:0]  up_cnt;
  logic [5:0]  dn_cnt;
  logic        any_nz;
  logic        smp_sat;
  logic        smp_bub;
  logic [5:0]  max_up_nxt;
  logic [5:0]  max_dn_nxt;
  logic [6:0]  timer_nxt;
  logic [6:0]  diff_held;
  logic [6:0]  diff_nxt;

  // Population count rather than leading-one position, so bubbles only cost an LSB.
  function automatic logic [5:0] popcount(input logic [31:0] code);
    logic [5:0] n;
    n = 6'd0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'd0, code[i]};
    end
    return n;
  endfunction

  function automatic logic is_bubble(input logic [31:0] code);
    logic [31:0] nxt;
    nxt = code + 32'd1;
    return (code != 32'd0) && ((code & nxt) != 32'd0);
  endfunction

  always_comb begin
    up_cnt     = popcount(up_q);
    dn_cnt     = popcount(dwn_q);
    any_nz     = (up_q != 32'd0) || (dwn_q != 32'd0);
    smp_sat    = (up_cnt == 6'd32) || (dn_cnt == 6'd32);
    smp_bub    = is_bubble(up_q) || is_bubble(dwn_q);
    max_up_nxt = (up_cnt > max_up) ? up_cnt : max_up;
    max_dn_nxt = (dn_cnt > max_dn) ? dn_cnt : max_dn;
    timer_nxt  = {1'b0, timer} + 7'd1;
    diff_held  = {1'b0, max_up} - {1'b0, max_dn};
    diff_nxt   = {1'b0, max_up_nxt} - {1'b0, max_dn_nxt};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      up_q        <= 32'd0;
      dwn_q       <= 32'd0;
      max_up      <= 6'd0;
      max_dn      <= 6'd0;
      timer       <= 6'd0;
      sat_acc     <= 1'b0;
      bub_acc     <= 1'b0;
      phase_err   <= 7'd0;
      err_valid   <= 1'b0;
      err_sat     <= 1'b0;
      err_bubble  <= 1'b0;
      err_timeout <= 1'b0;
      meas_count  <= 16'd0;
    end else begin
      up_q      <= up_error;
      dwn_q     <= dwn_error;
      err_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (any_nz) begin
            state   <= MEASURE;
            max_up  <= up_cnt;
            max_dn  <= dn_cnt;
            timer   <= 6'd0;
            sat_acc <= smp_sat;
            bub_acc <= smp_bub;
          end
        end
        MEASURE: begin
          if (!any_nz) begin
            state       <= IDLE;
            phase_err   <= diff_held;
            err_sat     <= sat_acc;
            err_bubble  <= bub_acc;
            err_timeout <= 1'b0;
            err_valid   <= 1'b1;
            if (meas_count != 16'hFFFF) meas_count <= meas_count + 16'd1;
          end else begin
            max_up  <= max_up_nxt;
            max_dn  <= max_dn_nxt;
            sat_acc <= sat_acc | smp_sat;
            bub_acc <= bub_acc | smp_bub;
            timer   <= timer_nxt[5:0];
            // Stuck-high input: publish what was seen so far, including this sample.
            if (timer_nxt == TIMEOUT_W) begin
              state       <= HOLD;
              phase_err   <= diff_nxt;
              err_sat     <= sat_acc | smp_sat;
              err_bubble  <= bub_acc | smp_bub;
              err_timeout <= 1'b1;
              err_valid   <= 1'b1;
              if (meas_count != 16'hFFFF) meas_count <= meas_count + 16'd1;
            end
          end
        end
        HOLD: begin
          if (!any_nz) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_therm_decoder.sv
// Directed and randomized checks of tdc_therm_decoder against a per-transaction reference model.
module tb_tdc_therm_decoder;

  logic        clk;
  logic        reset;
  logic [31:0] up_error;
  logic [31:0] dwn_error;
  logic [6:0]  phase_err;
  logic        err_valid;
  logic        err_sat;
  logic        err_bubble;
  logic        err_timeout;
  logic [15:0] meas_count;

  int          n_cmp;
  int          n_err;
  int          pulse_cnt;
  int          exp_count;
  logic [31:0] seq_up [64];
  logic [31:0] seq_dn [64];

  tdc_therm_decoder #(.TIMEOUT(63)) dut (
    .clk        (clk),
    .reset      (reset),
    .up_error   (up_error),
    .dwn_error  (dwn_error),
    .phase_err  (phase_err),
    .err_valid  (err_valid),
    .err_sat    (err_sat),
    .err_bubble (err_bubble),
    .err_timeout(err_timeout),
    .meas_count (meas_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (err_valid === 1'b1) pulse_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_therm(input logic [31:0] x);
    int n;
    n = $countones(x);
    return x == 32'((64'd1 << n) - 64'd1);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_phase"},   32'(phase_err),   32'd0);
    check({tag, "_valid"},   32'(err_valid),   32'd0);
    check({tag, "_sat"},     32'(err_sat),     32'd0);
    check({tag, "_bubble"},  32'(err_bubble),  32'd0);
    check({tag, "_timeout"}, 32'(err_timeout), 32'd0);
    check({tag, "_count"},   32'(meas_count),  32'd0);
  endtask

  // Apply seq_up/seq_dn[0..len-1] then zeros; expect one publish 2 edges after the first zero.
  task automatic run_txn(input int len, input string tag);
    int         mu, md, cu, cd, p0, got, diff;
    logic       s, b;
    logic [6:0] ep;
    mu = 0; md = 0; s = 1'b0; b = 1'b0;
    for (int i = 0; i < len; i++) begin
      cu = $countones(seq_up[i]);
      cd = $countones(seq_dn[i]);
      if (cu > mu) mu = cu;
      if (cd > md) md = cd;
      if (cu == 32 || cd == 32) s = 1'b1;
      if (!is_therm(seq_up[i]) || !is_therm(seq_dn[i])) b = 1'b1;
    end
    diff = mu - md;
    ep   = diff[6:0];
    if (exp_count < 65535) exp_count++;
    p0 = pulse_cnt;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      up_error  = seq_up[i];
      dwn_error = seq_dn[i];
    end
    @(negedge clk);
    up_error  = 32'd0;
    dwn_error = 32'd0;
    got = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (err_valid === 1'b1 && got == 0) got = k;
    end
    check({tag, "_latency"}, 32'(got),          32'd2);
    check({tag, "_phase"},   32'(phase_err),    32'(ep));
    check({tag, "_sat"},     32'(err_sat),      32'(s));
    check({tag, "_bubble"},  32'(err_bubble),   32'(b));
    check({tag, "_timeout"}, 32'(err_timeout),  32'd0);
    check({tag, "_count"},   32'(meas_count),   32'(exp_count));
    check({tag, "_pulses"},  32'(pulse_cnt - p0), 32'd1);
    check({tag, "_vld_low"}, 32'(err_valid),    32'd0);
  endtask

  initial begin
    int          p0, got, len, n;
    logic [31:0] v;
    n_cmp = 0; n_err = 0; pulse_cnt = 0; exp_count = 0;
    reset = 1'b1; up_error = 32'd0; dwn_error = 32'd0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Ramp on UP only
    for (int i = 0; i < 5; i++) begin
      v = 32'((64'd1 << (i + 1)) - 64'd1);
      seq_up[i] = v;
      seq_dn[i] = 32'd0;
    end
    run_txn(5, "ramp_up");

    // DWN ramps to 12 ones, UP stops at 3 ones
    for (int i = 0; i < 12; i++) begin
      v = 32'((64'd1 << (i + 1)) - 64'd1);
      seq_dn[i] = v;
      seq_up[i] = (i < 3) ? v : 32'h7;
    end
    run_txn(12, "ramp_dn");

    for (int i = 0; i < 3; i++) begin
      seq_up[i] = 32'hFFFF_FFFF;
      seq_dn[i] = 32'd0;
    end
    run_txn(3, "full_scale");

    seq_up[0] = 32'h0000_000B; seq_dn[0] = 32'd0;
    run_txn(1, "bubble");

    seq_up[0] = 32'hF; seq_dn[0] = 32'hF;
    seq_up[1] = 32'h3; seq_dn[1] = 32'h7;
    run_txn(2, "equal");

    for (int t = 0; t < 10; t++) begin
      len = $urandom_range(1, 16);
      for (int i = 0; i < len; i++) begin
        n = $urandom_range(0, 32);
        v = 32'((64'd1 << n) - 64'd1);
        if ($urandom_range(0, 3) == 0) v = v ^ (32'd1 << $urandom_range(0, 31));
        seq_up[i] = v;
        n = $urandom_range(0, 32);
        v = 32'((64'd1 << n) - 64'd1);
        if ($urandom_range(0, 3) == 0) v = v ^ (32'd1 << $urandom_range(0, 31));
        seq_dn[i] = v;
        if (seq_up[i] == 32'd0 && seq_dn[i] == 32'd0) seq_up[i] = 32'd1;
      end
      run_txn(len, $sformatf("rand%0d", t));
    end

    // Stuck input: publish after 63 MEASURE cycles (edge 1 registers, edge 2 leaves IDLE)
    @(negedge clk);
    up_error = 32'h1; dwn_error = 32'd0;
    p0 = pulse_cnt; got = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (err_valid === 1'b1 && got == 0) got = c;
    end
    exp_count++;
    check("timeout_latency", 32'(got),         32'd65);
    check("timeout_flag",    32'(err_timeout), 32'd1);
    check("timeout_phase",   32'(phase_err),   32'd1);
    check("timeout_sat",     32'(err_sat),     32'd0);
    check("timeout_bubble",  32'(err_bubble),  32'd0);
    check("timeout_count",   32'(meas_count),  32'(exp_count));
    up_error = 32'd0;
    repeat (10) @(negedge clk);
    check("timeout_pulses",  32'(pulse_cnt - p0), 32'd1);
    check("timeout_hold",    32'(err_timeout), 32'd1);

    // Reset in the middle of a measurement discards it
    @(negedge clk);
    up_error = 32'h7;
    repeat (5) @(negedge clk);
    p0 = pulse_cnt;
    reset = 1'b1; up_error = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    exp_count = 0;
    check("midreset_pulses", 32'(pulse_cnt - p0), 32'd0);
    check_all_zero("midreset");
    seq_up[0] = 32'h3; seq_dn[0] = 32'h1;
    run_txn(1, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tdc_therm_decoder.md
TDC_THERM_DECODER -- requirements
Module: tdc_therm_decoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: system sampling clock, same clock that drives the TDC shift registers.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset sampled on posedge clk.
REQ-003 SHALL have port up_error, input, 32 bits: UP thermometer code from the TDC phase detector.
REQ-004 SHALL have port dwn_error, input, 32 bits: DWN thermometer code from the TDC phase detector.
REQ-005 SHALL have port phase_err, output, 7 bits: signed two's-complement phase error, UP count minus DWN count, range -32..+32.
REQ-006 SHALL have port err_valid, output, 1 bit: one-cycle strobe marking a new phase_err.
REQ-007 SHALL have port err_sat, output, 1 bit: the published measurement reached count 32 on either code.
REQ-008 SHALL have port err_bubble, output, 1 bit: the published measurement contained a non-thermometer sample.
REQ-009 SHALL have port err_timeout, output, 1 bit: the published measurement was forced by timeout.
REQ-010 SHALL have port meas_count, output, 16 bits: number of published measurements, saturating at 0xFFFF.
REQ-011 SHALL have parameter TIMEOUT, default 63: number of MEASURE cycles before forced publish, range 1..63.

Function
REQ-012 SHALL register up_error and dwn_error into up_q and dwn_q every clk; all decoding uses up_q and dwn_q.
REQ-013 SHALL decode each registered code as its population count (0..32, 6 bits unsigned), which tolerates bubbles.
REQ-014 SHALL flag a sample as a bubble when a nonzero code is not of the form 2^n-1.
REQ-015 SHALL implement FSM states IDLE, MEASURE and HOLD, with IDLE as the reset state.
REQ-016 IDLE: when up_q or dwn_q is nonzero, SHALL go to MEASURE, load max_up and max_dn with the current counts, clear the timer, and initialise the sat/bubble accumulators from this sample.
REQ-017 MEASURE: each cycle SHALL update max_up and max_dn to the maximum of the held and current counts, OR the sat and bubble conditions into sticky accumulators, and increment the timer.
REQ-018 MEASURE: when up_q and dwn_q are both zero, SHALL publish and return to IDLE.
REQ-019 Publish SHALL register phase_err = max_up - max_dn (sign-extended to 7 bits), copy the sticky flags to err_sat and err_bubble, set err_timeout=0, and assert err_valid for exactly one cycle.
REQ-020 MEASURE: when the timer reaches TIMEOUT and either code is still nonzero, SHALL publish with err_timeout=1 and go to HOLD.
REQ-021 HOLD: SHALL remain in HOLD, without publishing, until up_q and dwn_q are both zero, then go to IDLE.
REQ-022 phase_err, err_sat, err_bubble and err_timeout SHALL hold their values between publishes.
REQ-023 meas_count SHALL increment on each publish and hold at 0xFFFF.
REQ-024 Latency: err_valid SHALL rise on the second clk edge after the first all-zero input sample (one edge for the input register, one for publish).
REQ-025 A single-cycle nonzero pulse followed by zero SHALL produce a valid publish.
REQ-026 Equal counts SHALL publish phase_err = 0.

Reset
REQ-027 When reset is high at posedge clk, the block SHALL set the state to IDLE and clear up_q, dwn_q, max_up, max_dn, the timer and the sticky flags.
REQ-028 Reset SHALL force phase_err=0, err_valid=0, err_sat=0, err_bubble=0, err_timeout=0 and meas_count=0.
REQ-029 Reset asserted during MEASURE or HOLD SHALL discard the measurement with no publish.
REQ-030 The first cycle after reset deasserts SHALL behave as IDLE.

Verification
REQ-031 Ramp up_error 0x1, 0x3 ... 0x1F, then 0, with dwn_error=0 -> one err_valid, phase_err=+5, all flags 0, meas_count=1.
REQ-032 Ramp dwn_error to 0xFFF and up_error to 0x7, both then 0 -> phase_err=-9 (7'h77), err_sat=0.
REQ-033 up_error=0xFFFFFFFF for 3 cycles, then 0 -> phase_err=+32, err_sat=1.
REQ-034 Apply up_error=0x0000000B (bubble), then 0 -> err_bubble=1, phase_err=+3.
REQ-035 Hold up_error=0x1 for 100 cycles with TIMEOUT=63 -> exactly one err_valid with err_timeout=1 after 63 MEASURE cycles; no further publish until the input returns to 0.
REQ-036 Assert reset mid-MEASURE -> no err_valid, all outputs 0; the next pulse with up=0x3 and dwn=0x1 publishes phase_err=+1 with meas_count=1.
